// File: rtl/noc_packet_arbiter_if.sv
// noc_packet_arbiter_if: flit/last/valid/ready bundle that connects INPUTS
// requesters and one shared output link channel to the packet arbiter.
interface noc_packet_arbiter_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int INPUTS     = 4
);
    logic [INPUTS-1:0][FLIT_WIDTH-1:0] in_flit;
    logic [INPUTS-1:0]                 in_last;
    logic [INPUTS-1:0]                 in_valid;
    logic [INPUTS-1:0]                 in_ready;
    logic [FLIT_WIDTH-1:0]             out_flit;
    logic                              out_last;
    logic                              out_valid;
    logic                              out_ready;

    // Arbiter side: consumes requester flits, drives the shared link
    modport master (
        input  in_flit,
        input  in_last,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_flit,
        output out_last,
        output out_valid
    );

    // Environment side: requesters plus the downstream link
    modport slave (
        output in_flit,
        output in_last,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_flit,
        input  out_last,
        input  out_valid
    );
endinterface

// File: rtl/noc_packet_arbiter.sv
// noc_packet_arbiter: round-robin, packet-locked arbiter sharing one NoC link
// channel between INPUTS requesters, with a sticky over-length packet flag.
// Optional macro NOC_ARB_PRIO_EN gives port 0 priority at every arbitration
// point (except its own last-flit re-arbitration); ports 1..INPUTS-1 then
// round-robin among themselves.
module noc_packet_arbiter #(
    parameter int FLIT_WIDTH  = 32,
    parameter int INPUTS      = 4,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    noc_packet_arbiter_if.master     bus,
    input  logic                     err_clr_i,
    output logic [INPUTS-1:0]        grant_o,
    output logic                     busy_o,
    output logic                     err_len_o
);

    localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_LEN);
    localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(MAX_PKT_LEN - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e              state_q;
    logic [INPUTS-1:0]   grant_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    flitCnt_q;
    logic [CNT_W-1:0]    flitCnt_d;
    logic                errLen_q;
    logic                errLen_d;

    logic [PTR_W-1:0]      ownerIdx;
    logic [PTR_W-1:0]      ptrNext;
    logic [INPUTS-1:0]     pickIdle;
    logic [INPUTS-1:0]     pickNext;
    logic [FLIT_WIDTH-1:0] outFlit;
    logic                  outLast;
    logic                  outValid;
    logic [INPUTS-1:0]     inReady;
    logic                  xfer;

    // First requester after position 'last', wrapping modulo INPUTS; the
    // port at 'last' itself is looked at only as the final candidate.
    function automatic logic [INPUTS-1:0] rrPick(input logic [INPUTS-1:0] req,
                                                 input logic [PTR_W-1:0]  last);
        logic [INPUTS-1:0] pick;
        logic [PTR_W-1:0]  sel;
        int                idx;
        pick = '0;
        for (int k = 1; k <= INPUTS; k++) begin
            idx = (int'(last) + k) % INPUTS;
            sel = PTR_W'(idx);
            if (pick == '0 && req[sel]) begin
                pick[sel] = 1'b1;
            end
        end
        return pick;
    endfunction

    // Encode the one-hot owner into an index for the data mux and pointer
    always_comb begin
        ownerIdx = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant_q[i]) begin
                ownerIdx = PTR_W'(i);
            end
        end
    end

    // Arbitration candidates for the IDLE pick and the last-flit hand-over
`ifdef NOC_ARB_PRIO_EN
    localparam logic [INPUTS-1:0] PORT0 = INPUTS'(1);
    always_comb begin
        ptrNext  = grant_q[0] ? ptr_q : ownerIdx;
        pickIdle = bus.in_valid[0] ? PORT0
                                   : rrPick(bus.in_valid & ~PORT0, ptr_q);
        pickNext = (bus.in_valid[0] && !grant_q[0]) ? PORT0
                   : rrPick(bus.in_valid & ~grant_q & ~PORT0, ptrNext);
    end
`else
    always_comb begin
        ptrNext  = ownerIdx;
        pickIdle = rrPick(bus.in_valid, ptr_q);
        pickNext = rrPick(bus.in_valid & ~grant_q, ptrNext);
    end
`endif

    // Forward the owner's channel combinationally while a packet is locked
    always_comb begin
        outFlit  = {FLIT_WIDTH{1'b0}};
        outLast  = 1'b0;
        outValid = 1'b0;
        inReady  = '0;
        if (state_q == BUSY) begin
            outFlit  = bus.in_flit[ownerIdx];
            outLast  = bus.in_last[ownerIdx];
            outValid = bus.in_valid[ownerIdx];
            inReady  = grant_q & {INPUTS{bus.out_ready}};
        end
    end

    assign xfer          = outValid && bus.out_ready;
    assign bus.out_flit  = outFlit;
    assign bus.out_last  = outLast;
    assign bus.out_valid = outValid;
    assign bus.in_ready  = inReady;

    // Saturating flit count and sticky length flag (a new set beats a clear)
    always_comb begin
        flitCnt_d = (flitCnt_q == CNT_MAX) ? flitCnt_q : flitCnt_q + CNT_W'(1);
        errLen_d  = errLen_q;
        if (xfer && !outLast && flitCnt_q == CNT_ERR) begin
            errLen_d = 1'b1;
        end else if (err_clr_i) begin
            errLen_d = 1'b0;
        end
    end

    // Arbiter FSM: lock a requester until its last flit, then hand over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PTR_W'(INPUTS - 1);
            flitCnt_q <= '0;
            errLen_q  <= 1'b0;
        end else begin
            errLen_q <= errLen_d;
            case (state_q)
                IDLE: begin
                    if (|bus.in_valid) begin
                        grant_q   <= pickIdle;
                        flitCnt_q <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        if (outLast) begin
                            ptr_q     <= ptrNext;
                            flitCnt_q <= '0;
                            grant_q   <= pickNext;
                            if (pickNext == '0) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            flitCnt_q <= flitCnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign busy_o    = (state_q == BUSY);
    assign err_len_o = errLen_q;

endmodule
